memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the max cycles a granted transfer may wait for ACCESS before error.
REQ-002 CLK  in  1  clock; all state updates on rising edge.
REQ-003 nRST  in  1  reset, asynchronous, active-low.
REQ-004 iREN  in  1  instruction-cache read request; iaddr  in  32  instruction address.
REQ-005 iload  out  32  read data to icache; iwait  out  1  icache stall (0 = transfer complete this cycle).
REQ-006 dREN  in  1  dcache read request; dWEN  in  1  dcache write request; daddr  in  32  address; dstore  in  32  write data.
REQ-007 dload  out  32  read data to dcache; dwait  out  1  dcache stall (0 = transfer complete this cycle).
REQ-008 ramREN  out  1, ramWEN  out  1, ramaddr  out  32, ramstore  out  32  RAM command; ramload  in  32  RAM read data.
REQ-009 ramstate  in  2  RAM status: 00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR.
REQ-010 err  out  1  sticky fault flag; dcount, icount  out  32 each  completed data/instruction transfer counters.

Function
REQ-011 FSM states SHALL be IDLE, DSERVE, ISERVE, ERR; grant SHALL be registered (one-cycle arbitration latency).
REQ-012 IDLE: dREN|dWEN -> DSERVE; else iREN -> ISERVE; else stay; data side always has priority.
REQ-013 IDLE outputs: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1.
REQ-014 DSERVE: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&!dWEN (write wins when both asserted), dload=ramload.
REQ-015 ISERVE: ramaddr=iaddr, ramREN=1, ramWEN=0, iload=ramload.
REQ-016 dwait SHALL be 0 only in DSERVE while ramstate==ACCESS; iwait 0 only in ISERVE while ramstate==ACCESS; all other cycles 1.
REQ-017 Completion (ACCESS in a serve state) SHALL return FSM to IDLE next cycle; each dcache word (e.g. two-word writeback/fill) is re-arbitrated individually.
REQ-018 If the granted requester drops its request (DSERVE with dREN=dWEN=0, or ISERVE with iREN=0), FSM SHALL go to IDLE without completion; no counter increment.
REQ-019 Non-granted requester SHALL see wait=1 and iload/dload=0 throughout.
REQ-020 Timeout counter SHALL clear on entry to a serve state, increment each serve cycle without ACCESS, and on reaching TIMEOUT move to ERR.
REQ-021 ramstate==ERROR in a serve state SHALL move to ERR next cycle; wait stays 1 that cycle.
REQ-022 ERR: err=1, ram commands 0, iwait=dwait=1; held until reset.
REQ-023 dcount/icount SHALL increment by 1 on each data/instruction completion and wrap from FFFFFFFF to 0.
REQ-024 Request and ACCESS in the same IDLE cycle SHALL NOT complete; ACCESS is honoured only in serve states.

Reset
REQ-025 nRST low SHALL force IDLE, err=0, dcount=icount=0, timeout counter=0 immediately, aborting any in-flight transfer.
REQ-026 During and after reset, until a grant, all RAM commands 0 and iwait=dwait=1.

Verification
REQ-027 iREN=1 iaddr=0x100, ramstate BUSY 2 cycles then ACCESS, ramload=0xDEADBEEF -> ramREN=1 from cycle 1, iwait=0 and iload=0xDEADBEEF in ACCESS cycle, icount=1.
REQ-028 iREN and dREN asserted together, daddr=0x200 -> DSERVE first; ISERVE only after dcache completes and drops requests; dcount=1 before icount=1.
REQ-029 dWEN=dREN=1, daddr=0x40, dstore=0x12345678 -> ramWEN=1, ramREN=0, ramstore=0x12345678; two back-to-back words (0x40, 0x44) -> dcount=2.
REQ-030 TIMEOUT=4, dREN=1, ramstate held BUSY -> ERR after 4 serve cycles, err=1, dwait stays 1, ram commands 0.
REQ-031 nRST pulsed low mid-DSERVE -> immediate IDLE, err=0, counters 0; ramstate ERROR during ISERVE -> err=1 next cycle.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// Memory arbiter bus: icache and dcache request/response, RAM command and status,
// fault flag and transfer counters.
// Modports:
//   master - the arbiter's view (drives RAM commands and cache responses)
//   slave  - the environment's view (caches and RAM drive requests and status)
interface memory_arbiter_if;
  // instruction cache
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  // data cache
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  // RAM
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  // status
  logic        err;
  logic [31:0] dcount;
  logic [31:0] icount;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore,
           err, dcount, icount
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore,
           err, dcount, icount
  );
endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates a single RAM port between the instruction and data caches.
// Data side has priority; the grant is registered, so a request seen in IDLE is
// served from the next cycle. Each word is re-arbitrated after completion.
// A RAM ERROR status or a transfer exceeding TIMEOUT non-ACCESS cycles parks the
// arbiter in ERR (sticky until reset).
// Ports:
//   CLK  - clock, rising edge
//   nRST - asynchronous active-low reset
//   bus  - memory_arbiter_if.master (cache, RAM, err and counter signals)
module memory_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic              CLK,
  input logic              nRST,
  memory_arbiter_if.master bus
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] RAM_FREE   = 2'b00;
  localparam logic [1:0] RAM_BUSY   = 2'b01;
  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [1:0] RAM_ERROR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DSERVE = 2'd1,
    ISERVE = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [31:0]   dcount;
  logic [31:0]   icount;

  logic d_req;
  logic ram_access;
  logic ram_error;
  logic tcnt_last;

  assign d_req      = bus.dREN | bus.dWEN;
  assign ram_access = (bus.ramstate == RAM_ACCESS);
  assign ram_error  = (bus.ramstate == RAM_ERROR);
  // This serve cycle is the TIMEOUT-th one without ACCESS.
  assign tcnt_last  = (tcnt == TW'(TIMEOUT - 1));

  // State, timeout counter and completion counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      tcnt   <= '0;
      dcount <= '0;
      icount <= '0;
    end else begin
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (d_req)         state <= DSERVE;
          else if (bus.iREN) state <= ISERVE;
        end
        DSERVE: begin
          if (ram_error)       state <= ERR;
          else if (!d_req)     state <= IDLE;
          else if (ram_access) begin
            state  <= IDLE;
            dcount <= dcount + 32'd1;
          end
          else if (tcnt_last)  state <= ERR;
          else                 tcnt  <= tcnt + TW'(1);
        end
        ISERVE: begin
          if (ram_error)       state <= ERR;
          else if (!bus.iREN)  state <= IDLE;
          else if (ram_access) begin
            state  <= IDLE;
            icount <= icount + 32'd1;
          end
          else if (tcnt_last)  state <= ERR;
          else                 tcnt  <= tcnt + TW'(1);
        end
        ERR:     state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode: RAM command follows the granted requester; the ACCESS status
  // releases the wait in the same cycle.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = 32'd0;
    bus.ramstore = 32'd0;
    bus.iload    = 32'd0;
    bus.dload    = 32'd0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    case (state)
      DSERVE: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.dload    = bus.ramload;
        bus.dwait    = ~ram_access;
      end
      ISERVE: begin
        bus.ramaddr = bus.iaddr;
        bus.ramREN  = 1'b1;
        bus.iload   = bus.ramload;
        bus.iwait   = ~ram_access;
      end
      default: ;
    endcase
  end

  assign bus.err    = (state == ERR);
  assign bus.dcount = dcount;
  assign bus.icount = icount;

  // FREE and BUSY both mean "not yet"; named for readability only.
  logic unused_ok;
  assign unused_ok = (RAM_FREE == RAM_BUSY);

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed test for memory_arbiter (TIMEOUT=4). Inputs change 1 ns after the
// rising edge; outputs are sampled 1 ns later, away from the edge.
module tb_memory_arbiter;

  logic CLK = 1'b0;
  logic nRST;
  int   checks = 0;
  int   errors = 0;

  memory_arbiter_if bus ();

  memory_arbiter #(.TIMEOUT(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  localparam logic [1:0] FREE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;
  localparam logic [1:0] ERROR  = 2'b11;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST         = 1'b0;
    bus.iREN     = 1'b0;
    bus.iaddr    = 32'd0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = 32'd0;
    bus.dstore   = 32'd0;
    bus.ramload  = 32'd0;
    bus.ramstate = FREE;
    #2;
    check("rst_ramREN", 32'(bus.ramREN), 32'd0);
    check("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    check("rst_iwait",  32'(bus.iwait),  32'd1);
    check("rst_dwait",  32'(bus.dwait),  32'd1);
    check("rst_err",    32'(bus.err),    32'd0);
    check("rst_dcount", bus.dcount,      32'd0);
    check("rst_icount", bus.icount,      32'd0);
    nxt();
    nRST = 1'b1;
    nxt();

    // Instruction read: BUSY, BUSY, ACCESS.
    bus.iREN = 1'b1; bus.iaddr = 32'h100; bus.ramstate = BUSY; bus.ramload = 32'hDEADBEEF;
    #1;
    check("i_idle_ramREN", 32'(bus.ramREN), 32'd0);
    check("i_idle_iwait",  32'(bus.iwait),  32'd1);
    nxt();
    #1;
    check("i_c1_ramREN",  32'(bus.ramREN), 32'd1);
    check("i_c1_ramaddr", bus.ramaddr,     32'h100);
    check("i_c1_iwait",   32'(bus.iwait),  32'd1);
    nxt();
    #1;
    check("i_c2_iwait", 32'(bus.iwait), 32'd1);
    nxt();
    bus.ramstate = ACCESS;
    #1;
    check("i_acc_iwait", 32'(bus.iwait), 32'd0);
    check("i_acc_iload", bus.iload,      32'hDEADBEEF);
    check("i_acc_dwait", 32'(bus.dwait), 32'd1);
    check("i_acc_dload", bus.dload,      32'd0);
    nxt();
    bus.iREN = 1'b0; bus.ramstate = FREE;
    #1;
    check("i_done_icount", bus.icount,      32'd1);
    check("i_done_ramREN", 32'(bus.ramREN), 32'd0);

    // Simultaneous requests: data first, then instruction.
    bus.iREN = 1'b1; bus.iaddr = 32'h300; bus.dREN = 1'b1; bus.daddr = 32'h200;
    nxt();
    #1;
    check("pri_ramaddr", bus.ramaddr,     32'h200);
    check("pri_ramREN",  32'(bus.ramREN), 32'd1);
    check("pri_iwait",   32'(bus.iwait),  32'd1);
    bus.ramstate = ACCESS; bus.ramload = 32'h0000A5A5;
    #1;
    check("pri_dwait", 32'(bus.dwait), 32'd0);
    check("pri_dload", bus.dload,      32'h0000A5A5);
    check("pri_iload", bus.iload,      32'd0);
    check("pri_iwait2", 32'(bus.iwait), 32'd1);
    nxt();
    bus.dREN = 1'b0; bus.ramstate = FREE;
    #1;
    check("pri_dcount", bus.dcount, 32'd1);
    check("pri_icount", bus.icount, 32'd1);
    nxt();
    #1;
    check("pri_i_ramaddr", bus.ramaddr, 32'h300);
    bus.ramstate = ACCESS; bus.ramload = 32'h00001111;
    #1;
    check("pri_i_iload", bus.iload,      32'h00001111);
    check("pri_i_iwait", 32'(bus.iwait), 32'd0);
    nxt();
    bus.iREN = 1'b0; bus.ramstate = FREE;
    #1;
    check("pri_icount2", bus.icount, 32'd2);

    // Two-word writeback with both dREN and dWEN high.
    bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h40; bus.dstore = 32'h12345678;
    nxt();
    #1;
    check("wr0_ramWEN",   32'(bus.ramWEN), 32'd1);
    check("wr0_ramREN",   32'(bus.ramREN), 32'd0);
    check("wr0_ramstore", bus.ramstore,    32'h12345678);
    check("wr0_ramaddr",  bus.ramaddr,     32'h40);
    bus.ramstate = ACCESS;
    #1;
    check("wr0_dwait", 32'(bus.dwait), 32'd0);
    nxt();
    // Back in IDLE with ACCESS still showing: must not complete here.
    bus.daddr = 32'h44; bus.dstore = 32'h9ABCDEF0;
    #1;
    check("wr1_idle_dwait",  32'(bus.dwait), 32'd1);
    check("wr1_idle_dcount", bus.dcount,     32'd2);
    nxt();
    #1;
    check("wr1_ramaddr",  bus.ramaddr,     32'h44);
    check("wr1_ramstore", bus.ramstore,    32'h9ABCDEF0);
    check("wr1_dwait",    32'(bus.dwait),  32'd0);
    nxt();
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.ramstate = FREE;
    #1;
    check("wr_dcount", bus.dcount, 32'd3);

    // Requester drops mid-transfer: back to IDLE without counting.
    bus.iREN = 1'b1; bus.ramstate = BUSY;
    nxt();
    #1;
    check("drop_ramREN", 32'(bus.ramREN), 32'd1);
    bus.iREN = 1'b0;
    nxt();
    #1;
    check("drop_idle_ramREN", 32'(bus.ramREN), 32'd0);
    check("drop_icount",      bus.icount,      32'd2);

    // Asynchronous reset in the middle of a data transfer.
    bus.dREN = 1'b1; bus.daddr = 32'h80;
    nxt();
    #1;
    check("rstm_ramREN", 32'(bus.ramREN), 32'd1);
    nRST = 1'b0;
    #1;
    check("rstm_ramREN0", 32'(bus.ramREN), 32'd0);
    check("rstm_dwait",   32'(bus.dwait),  32'd1);
    check("rstm_dcount",  bus.dcount,      32'd0);
    check("rstm_icount",  bus.icount,      32'd0);
    check("rstm_err",     32'(bus.err),    32'd0);
    bus.dREN = 1'b0;
    nxt();
    nRST = 1'b1;
    nxt();

    // RAM ERROR during an instruction transfer.
    bus.iREN = 1'b1; bus.ramstate = FREE;
    nxt();
    bus.ramstate = ERROR;
    #1;
    check("ierr_iwait", 32'(bus.iwait), 32'd1);
    check("ierr_err0",  32'(bus.err),   32'd0);
    nxt();
    #1;
    check("ierr_err1",   32'(bus.err),    32'd1);
    check("ierr_ramREN", 32'(bus.ramREN), 32'd0);
    check("ierr_iwait2", 32'(bus.iwait),  32'd1);
    bus.iREN = 1'b0; bus.ramstate = FREE;
    nRST = 1'b0;
    #1;
    check("ierr_clr", 32'(bus.err), 32'd0);
    nxt();
    nRST = 1'b1;
    nxt();

    // Timeout: BUSY forever, ERR after four serve cycles.
    bus.dREN = 1'b1; bus.daddr = 32'h500; bus.ramstate = BUSY;
    nxt();
    nxt();
    nxt();
    nxt();
    #1;
    check("to_c4_err",    32'(bus.err),    32'd0);
    check("to_c4_ramREN", 32'(bus.ramREN), 32'd1);
    nxt();
    #1;
    check("to_err",     32'(bus.err),    32'd1);
    check("to_dwait",   32'(bus.dwait),  32'd1);
    check("to_ramREN",  32'(bus.ramREN), 32'd0);
    check("to_ramaddr", bus.ramaddr,     32'd0);
    bus.ramstate = ACCESS;
    nxt();
    #1;
    check("to_hold_err",   32'(bus.err),   32'd1);
    check("to_hold_dwait", 32'(bus.dwait), 32'd1);
    check("to_dcount",     bus.dcount,     32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
